sram_dump: RTL and testbench

//  Reads back the four byte-lane SRAM banks (CEN/GWEN/WEN/A/D/Q macro interface) and streams contents out as bytes.

---
 rtl/sram_dump_pkg.sv | 20 ++
 rtl/sram_dump.sv | 132 +++++++++++++
 tb/tb_sram_dump.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_dump_pkg.sv
// Shared types and sizes for the byte-lane SRAM dump engine.
// Holds the bank geometry, the dump FSM state encoding and the lane byte bundle.
// Imported by the dump block and by anything that talks to its bank ports.
package sram_dump_pkg;

   localparam int SRAM_ADDR_W = 9;
   localparam int SRAM_LANES  = 4;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      CAPT,
      SEND,
      DONE
   } dump_state_t;

   // One byte per bank, lane 0 in the low byte.
   typedef logic [SRAM_LANES-1:0][7:0] lane_bytes_t;

endpackage

// File: rtl/sram_dump.sv
// Reads the byte-lane SRAM banks word by word and streams bytes out, lane 0 first.
// Latency: first out_valid two cycles after start; 4 bytes per 6 cycles with out_ready held high.
// Backpressure: out_data/out_valid hold while out_ready is low; no new bank read until the word is fully sent.
module sram_dump
   import sram_dump_pkg::*;
#(
   parameter int ADDR_W = SRAM_ADDR_W,
   parameter int LANES  = SRAM_LANES,
   parameter int CNT_W  = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [ADDR_W-1:0]        start_addr,
   input  logic [CNT_W-1:0]         word_cnt,
   input  logic                     abort,
   output logic                     busy,
   output logic                     done,
   output logic [LANES-1:0]         CEN,
   output logic [LANES-1:0]         GWEN,
   output logic [8*LANES-1:0]       WEN,
   output logic [ADDR_W*LANES-1:0]  A,
   output logic [8*LANES-1:0]       D,
   input  logic [8*LANES-1:0]       Q,
   output logic [7:0]               out_data,
   output logic                     out_valid,
   input  logic                     out_ready
);

   localparam int                LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

   dump_state_t            state_q;
   dump_state_t            state_d;
   logic [ADDR_W-1:0]      addr_q;
   logic [CNT_W-1:0]       rem_q;
   logic [LANE_W-1:0]      lane_q;
   logic [LANES-1:0][7:0]  buf_q;
   logic                   hs;
   logic                   word_sent;

   assign hs        = (state_q == SEND) && out_ready;
   assign word_sent = hs && (lane_q == LAST_LANE);

   // State register; async reset parks the engine in IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and handshake outputs; abort overrides every other transition.
   always_comb begin
      state_d   = state_q;
      busy      = (state_q != IDLE);
      done      = (state_q == DONE);
      out_valid = (state_q == SEND);
      out_data  = '0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = (word_cnt != '0) ? READ : DONE;
            end
         end
         READ: state_d = CAPT;
         CAPT: state_d = SEND;
         SEND: begin
            out_data = buf_q[lane_q];
            if (word_sent) begin
               state_d = (rem_q == CNT_W'(1)) ? DONE : READ;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort) begin
         state_d = IDLE;
      end
   end

   // Address, remaining-word count, lane pointer and captured word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q <= '0;
         rem_q  <= '0;
         lane_q <= '0;
         buf_q  <= '0;
      end else if (!abort) begin
         case (state_q)
            IDLE: begin
               if (start && (word_cnt != '0)) begin
                  addr_q <= start_addr;
                  rem_q  <= word_cnt;
               end
            end
            CAPT: begin
               buf_q  <= Q;
               lane_q <= '0;
            end
            SEND: begin
               if (hs) begin
                  if (lane_q != LAST_LANE) begin
                     lane_q <= lane_q + LANE_W'(1);
                  end else if (rem_q != CNT_W'(1)) begin
                     // Natural wrap of the address width gives 511+1 -> 0.
                     addr_q <= addr_q + ADDR_W'(1);
                     rem_q  <= rem_q - CNT_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Bank ports: every lane reads the same word in READ, idle and write-protected otherwise.
   always_comb begin
      CEN  = {LANES{state_q != READ}};
      GWEN = '1;
      WEN  = '1;
      D    = '0;
      A    = '0;
      for (int i = 0; i < LANES; i++) begin
         if (state_q == READ) begin
            A[i*ADDR_W +: ADDR_W] = addr_q;
         end
      end
   end

endmodule

// File: tb/tb_sram_dump.sv
// Directed bench for sram_dump with a behavioural four-bank SRAM model.
// Banks are preloaded through an init mux while rst is high; byte at word w, lane l is (4w+l+1) mod 256.
// A negedge monitor records accepted bytes, done pulses and bank read addresses.
module tb_sram_dump;
   import sram_dump_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [8:0]  start_addr;
   logic [9:0]  word_cnt;
   logic        abort;
   logic        busy;
   logic        done;
   logic [3:0]  CEN;
   logic [3:0]  GWEN;
   logic [31:0] WEN;
   logic [35:0] A;
   logic [31:0] D;
   lane_bytes_t q_bank;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;

   logic        init_we;
   logic [8:0]  init_addr;
   logic [31:0] init_word;
   logic [7:0]  mem [4][512];

   int          n_cmp = 0;
   int          n_err = 0;
   logic [7:0]  got [$];
   logic [8:0]  a_seen [$];
   int          done_cnt;
   int          cen_low_cnt;
   int          lane_skew;

   always #5 clk = ~clk;

   sram_dump dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .start_addr (start_addr),
      .word_cnt   (word_cnt),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .CEN        (CEN),
      .GWEN       (GWEN),
      .WEN        (WEN),
      .A          (A),
      .D          (D),
      .Q          (q_bank),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   // SRAM banks: init port owns them during rst, the dump engine otherwise.
   always @(posedge clk) begin
      for (int l = 0; l < 4; l++) begin
         if (rst) begin
            if (init_we) mem[l][init_addr] <= init_word[l*8 +: 8];
         end else if (!CEN[l]) begin
            if (!GWEN[l]) mem[l][A[l*9 +: 9]] <= D[l*8 +: 8];
            else          q_bank[l]           <= mem[l][A[l*9 +: 9]];
         end
      end
   end

   // Monitor sampled mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) got.push_back(out_data);
         if (done) done_cnt++;
         if (CEN !== 4'hF) begin
            cen_low_cnt++;
            a_seen.push_back(A[8:0]);
            if (CEN !== 4'h0 || A[17:9] !== A[8:0] || A[26:18] !== A[8:0] || A[35:27] !== A[8:0])
               lane_skew++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      got.delete();
      a_seen.delete();
      done_cnt    = 0;
      cen_low_cnt = 0;
      lane_skew   = 0;
   endtask

   task automatic start_pulse(input logic [8:0] sa, input logic [9:0] cnt);
      start      = 1'b1;
      start_addr = sa;
      word_cnt   = cnt;
      cyc();
      start      = 1'b0;
   endtask

   task automatic wait_done(input int max, output int n);
      n = 0;
      while (done !== 1'b1 && n < max) begin
         cyc();
         n++;
      end
   endtask

   task automatic preload(input int w);
      init_we   = 1'b1;
      init_addr = 9'(w);
      for (int l = 0; l < 4; l++) init_word[l*8 +: 8] = 8'(w*4 + l + 1);
      cyc();
      init_we   = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
      start_addr = '0; word_cnt = '0; init_we = 1'b0; init_addr = '0; init_word = '0;
      cyc();
      for (int w = 0; w < 8; w++) preload(w);
      preload(511);
      n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_cmp++; if (done !== 1'b0)       begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
      n_cmp++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      n_cmp++; if (out_data !== 8'h00)  begin n_err++; $display("FAIL reset_data: got %h expected 00", out_data); end
      n_cmp++; if (CEN !== 4'hF)        begin n_err++; $display("FAIL reset_cen: got %h expected f", CEN); end
      n_cmp++; if (GWEN !== 4'hF)       begin n_err++; $display("FAIL reset_gwen: got %h expected f", GWEN); end
      n_cmp++; if (WEN !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL reset_wen: got %h expected ffffffff", WEN); end
      n_cmp++; if (A !== 36'h0)         begin n_err++; $display("FAIL reset_addr: got %h expected 0", A); end
      n_cmp++; if (D !== 32'h0)         begin n_err++; $display("FAIL reset_d: got %h expected 0", D); end
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_basic();
      int n;
      clear_mon();
      out_ready = 1'b1;
      start_pulse(9'd0, 10'd2);
      n_cmp++; if (CEN !== 4'h0 || busy !== 1'b1) begin n_err++; $display("FAIL basic_read: cen %h busy %b expected cen 0 busy 1", CEN, busy); end
      cyc(); cyc();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h01) begin n_err++; $display("FAIL basic_first: valid %b data %h expected 1 01", out_valid, out_data); end
      wait_done(40, n);
      n_cmp++; if (n !== 10) begin n_err++; $display("FAIL basic_done_time: got %0d cycles expected 12", n + 2); end
      n_cmp++; if (got.size() !== 8) begin n_err++; $display("FAIL basic_count: got %0d bytes expected 8", got.size()); end
      for (int i = 0; i < 8; i++) begin
         n_cmp++; if (got[i] !== 8'(i + 1)) begin n_err++; $display("FAIL basic_byte%0d: got %h expected %h", i, got[i], 8'(i + 1)); end
      end
      cyc();
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0 || done_cnt !== 1) begin n_err++; $display("FAIL basic_end: done %b busy %b pulses %0d expected 0 0 1", done, busy, done_cnt); end
   endtask

   task automatic test_zero();
      clear_mon();
      start_pulse(9'd5, 10'd0);
      n_cmp++; if (done !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL zero_done: done %b valid %b expected 1 0", done, out_valid); end
      cyc();
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL zero_end: done %b busy %b expected 0 0", done, busy); end
      cyc();
      n_cmp++; if (cen_low_cnt !== 0 || got.size() !== 0 || done_cnt !== 1) begin n_err++; $display("FAIL zero_activity: reads %0d bytes %0d pulses %0d expected 0 0 1", cen_low_cnt, got.size(), done_cnt); end
   endtask

   task automatic test_wrap();
      int n;
      logic [7:0] exp_b [8] = '{8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
      clear_mon();
      start_pulse(9'd511, 10'd2);
      wait_done(40, n);
      n_cmp++; if (n !== 12) begin n_err++; $display("FAIL wrap_done_time: got %0d expected 12", n); end
      n_cmp++; if (a_seen.size() !== 2 || a_seen[0] !== 9'd511 || a_seen[1] !== 9'd0) begin n_err++; $display("FAIL wrap_addr: reads %0d first %0d second %0d expected 2 511 0", a_seen.size(), a_seen[0], a_seen[1]); end
      n_cmp++; if (lane_skew !== 0) begin n_err++; $display("FAIL wrap_lanes: got %0d skewed reads expected 0", lane_skew); end
      for (int i = 0; i < 8; i++) begin
         n_cmp++; if (got[i] !== exp_b[i]) begin n_err++; $display("FAIL wrap_byte%0d: got %h expected %h", i, got[i], exp_b[i]); end
      end
      cyc();
   endtask

   task automatic test_stall();
      int n;
      clear_mon();
      out_ready = 1'b1;
      start_pulse(9'd4, 10'd2);
      cyc(); cyc(); cyc(); cyc();
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cyc();
         n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h13) begin n_err++; $display("FAIL stall_hold%0d: valid %b data %h expected 1 13", k, out_valid, out_data); end
      end
      out_ready = 1'b1;
      wait_done(40, n);
      n_cmp++; if (got.size() !== 8) begin n_err++; $display("FAIL stall_count: got %0d bytes expected 8", got.size()); end
      for (int i = 0; i < 8; i++) begin
         n_cmp++; if (got[i] !== 8'(8'h11 + i)) begin n_err++; $display("FAIL stall_byte%0d: got %h expected %h", i, got[i], 8'(8'h11 + i)); end
      end
      cyc();
   endtask

   task automatic test_abort();
      int n;
      clear_mon();
      out_ready = 1'b1;
      start_pulse(9'd2, 10'd2);
      cyc(); cyc(); cyc(); cyc();
      n_cmp++; if (out_data !== 8'h0B) begin n_err++; $display("FAIL abort_lane2: got %h expected 0b", out_data); end
      abort = 1'b1; out_ready = 1'b0;
      cyc();
      abort = 1'b0;
      n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0 || CEN !== 4'hF) begin n_err++; $display("FAIL abort_idle: busy %b valid %b cen %h expected 0 0 f", busy, out_valid, CEN); end
      cyc(); cyc(); cyc();
      n_cmp++; if (done_cnt !== 0 || got.size() !== 2) begin n_err++; $display("FAIL abort_nodone: pulses %0d bytes %0d expected 0 2", done_cnt, got.size()); end
      clear_mon();
      out_ready = 1'b1;
      start_pulse(9'd6, 10'd1);
      wait_done(20, n);
      n_cmp++; if (n !== 6) begin n_err++; $display("FAIL abort_restart_time: got %0d expected 6", n); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (got[i] !== 8'(8'h19 + i)) begin n_err++; $display("FAIL abort_restart_byte%0d: got %h expected %h", i, got[i], 8'(8'h19 + i)); end
      end
      cyc();
   endtask

   task automatic test_rst_mid();
      int n;
      clear_mon();
      out_ready = 1'b1;
      start_pulse(9'd0, 10'd3);
      n_cmp++; if (CEN !== 4'h0) begin n_err++; $display("FAIL rst_read: cen %h expected 0", CEN); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (CEN !== 4'hF || busy !== 1'b0 || out_valid !== 1'b0 || A !== 36'h0) begin n_err++; $display("FAIL rst_async: cen %h busy %b valid %b a %h expected f 0 0 0", CEN, busy, out_valid, A); end
      cyc();
      rst = 1'b0;
      cyc(); cyc();
      n_cmp++; if (busy !== 1'b0 || done_cnt !== 0 || got.size() !== 0) begin n_err++; $display("FAIL rst_quiet: busy %b pulses %0d bytes %0d expected 0 0 0", busy, done_cnt, got.size()); end
      clear_mon();
      start_pulse(9'd0, 10'd1);
      cyc(); cyc(); cyc();
      start_pulse(9'd500, 10'd3);
      wait_done(20, n);
      n_cmp++; if (n !== 2) begin n_err++; $display("FAIL busy_start_time: got %0d expected 2", n); end
      cyc(); cyc();
      n_cmp++; if (got.size() !== 4 || done_cnt !== 1 || a_seen.size() !== 1 || busy !== 1'b0) begin n_err++; $display("FAIL busy_start_ignored: bytes %0d pulses %0d reads %0d busy %b expected 4 1 1 0", got.size(), done_cnt, a_seen.size(), busy); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (got[i] !== 8'(i + 1)) begin n_err++; $display("FAIL busy_start_byte%0d: got %h expected %h", i, got[i], 8'(i + 1)); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero();
      test_wrap();
      test_stall();
      test_abort();
      test_rst_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
